// File: rtl/rr_grant_scheduler_pkg.sv
// rtl/rr_grant_scheduler_pkg.sv - shared state encodings and helpers for the round-robin grant scheduler
package rr_grant_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_pick.sv
// rtl/rr_grant_scheduler_pick.sv - combinational rotating-priority encoder, search starts at last+1
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] pick,
  output logic [ID_W-1:0]    pick_id,
  output logic               any
);

  logic [ID_W-1:0] idx;

  // Walk offsets 1..NUM_REQ so the previous owner is checked last.
  always_comb begin
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= 32'(NUM_REQ); k++) begin
      idx = ID_W'((32'(last) + k) % 32'(NUM_REQ));
      if (!any && req[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_id   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// rtl/rr_grant_scheduler.sv - round-robin arbiter with hold limit and one-cycle turnaround gap
module rr_grant_scheduler
  import rr_grant_scheduler_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = 2,
  parameter int HOLD_W   = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               preempt
);

  sched_state_t        state, state_d;
  logic [ID_W-1:0]     last, last_d;
  logic [HOLD_W-1:0]   hold_cnt, hold_d;
  logic [NUM_REQ-1:0]  gnt_d;
  logic                gnt_valid_d;
  logic [ID_W-1:0]     gnt_id_d;
  logic                preempt_d;

  logic [NUM_REQ-1:0]  pick;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;
  logic                owner_req;
  logic                others_pending;
  logic                hold_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req),
    .last    (last),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (pick_any)
  );

  assign owner_req      = |(req & gnt);
  assign others_pending = |(req & ~gnt);
  assign hold_hit       = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      last      <= ID_W'(NUM_REQ - 1);
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_d;
      last      <= last_d;
      hold_cnt  <= hold_d;
      gnt       <= gnt_d;
      gnt_valid <= gnt_valid_d;
      gnt_id    <= gnt_id_d;
      preempt   <= preempt_d;
    end
  end

  always_comb begin
    state_d     = state;
    last_d      = last;
    hold_d      = hold_cnt;
    gnt_d       = gnt;
    gnt_valid_d = gnt_valid;
    gnt_id_d    = gnt_id;
    preempt_d   = 1'b0;
    case (state)
      // GAP re-arbitrates directly so the turnaround is exactly one cycle.
      ST_IDLE, ST_GAP: begin
        if (pick_any) begin
          state_d     = ST_GRANT;
          gnt_d       = pick;
          gnt_valid_d = 1'b1;
          gnt_id_d    = pick_id;
          last_d      = pick_id;
          hold_d      = HOLD_W'(1);
        end else begin
          state_d     = ST_IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || (hold_hit && others_pending)) begin
          state_d     = ST_GAP;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
          preempt_d   = owner_req;
        end else if ((MAX_HOLD != 0) && !hold_hit) begin
          hold_d = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb/tb_rr_grant_scheduler.sv - directed self-checking bench for rr_grant_scheduler (MAX_HOLD=4)
module tb_rr_grant_scheduler;

  logic       clock;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       preempt;

  int checks;
  int errors;

  rr_grant_scheduler #(
    .NUM_REQ  (4),
    .MAX_HOLD (4),
    .ID_W     (2),
    .HOLD_W   (3)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .preempt   (preempt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic pre);
    check({tag, "_gnt"}, 32'(gnt), 32'(g));
    check({tag, "_valid"}, 32'(gnt_valid), 32'(g != 4'b0000));
    check({tag, "_id"}, 32'(gnt_id), 32'(id));
    check({tag, "_preempt"}, 32'(preempt), 32'(pre));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    expect_out("reset", 4'b0000, 2'd0, 1'b0);
    reset_n = 1'b1;
  endtask

  function automatic logic [1:0] id_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Per-cycle invariants: one-hot/zero, id/valid consistency, no owner swap without a gap.
  logic [3:0] prev_gnt;
  always @(negedge clock) begin
    check("inv_onehot", 32'($countones(gnt) <= 1), 32'd1);
    check("inv_valid", 32'(gnt_valid), 32'(|gnt));
    check("inv_id", 32'(gnt_id), 32'(id_of(gnt)));
    if (prev_gnt != 4'b0000 && gnt != 4'b0000) begin
      check("inv_nogap_switch", 32'(gnt), 32'(prev_gnt));
    end
    prev_gnt = gnt;
  end

  initial begin
    checks   = 0;
    errors   = 0;
    prev_gnt = 4'b0000;
    reset_n  = 1'b0;
    req      = 4'b0000;
    #2;

    // 1: single requester, release, one gap then idle
    do_reset();
    req = 4'b0001;
    tick(); expect_out("t1_c1", 4'b0001, 2'd0, 1'b0);
    tick(); expect_out("t1_c2", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    tick(); expect_out("t1_gap", 4'b0000, 2'd0, 1'b0);
    tick(); expect_out("t1_idle", 4'b0000, 2'd0, 1'b0);

    // 2: all requesting, each owner releases after 3 cycles -> 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        expect_out("t2_own", 4'(1 << (n % 4)), 2'(n % 4), 1'b0);
      end
      req[n % 4] = 1'b0;
      tick(); expect_out("t2_gap", 4'b0000, 2'd0, 1'b0);
      req[n % 4] = 1'b1;
    end
    req = 4'b0000;
    tick();

    // 3: hold limit preempts req[2] in favour of req[0]
    do_reset();
    req = 4'b0100;
    tick(); expect_out("t3_c1", 4'b0100, 2'd2, 1'b0);
    tick(); expect_out("t3_c2", 4'b0100, 2'd2, 1'b0);
    req = 4'b0101;
    tick(); expect_out("t3_c3", 4'b0100, 2'd2, 1'b0);
    tick(); expect_out("t3_c4", 4'b0100, 2'd2, 1'b0);
    tick(); expect_out("t3_preempt", 4'b0000, 2'd0, 1'b1);
    tick(); expect_out("t3_next", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    tick();

    // 4: lone requester is never preempted
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      tick(); expect_out("t4_hold", 4'b0010, 2'd1, 1'b0);
    end
    req = 4'b0000;
    tick(); expect_out("t4_gap", 4'b0000, 2'd0, 1'b0);

    // 5: reset in the middle of a grant to requester 3
    do_reset();
    req = 4'b1000;
    tick(); expect_out("t5_c1", 4'b1000, 2'd3, 1'b0);
    tick(); expect_out("t5_c2", 4'b1000, 2'd3, 1'b0);
    reset_n = 1'b0;
    tick(); expect_out("t5_reset", 4'b0000, 2'd0, 1'b0);
    reset_n = 1'b1;
    req = 4'b1010;
    tick(); expect_out("t5_after", 4'b0010, 2'd1, 1'b0);
    req = 4'b0000;
    tick();

    // 6: owner releases in its hold-limit cycle -> normal gap, no preempt
    do_reset();
    req = 4'b0001;
    tick(); expect_out("t6_c1", 4'b0001, 2'd0, 1'b0);
    req = 4'b0101;
    tick(); expect_out("t6_c2", 4'b0001, 2'd0, 1'b0);
    tick(); expect_out("t6_c3", 4'b0001, 2'd0, 1'b0);
    tick(); expect_out("t6_c4", 4'b0001, 2'd0, 1'b0);
    req = 4'b0100;
    tick(); expect_out("t6_gap", 4'b0000, 2'd0, 1'b0);
    tick(); expect_out("t6_next", 4'b0100, 2'd2, 1'b0);
    req = 4'b0000;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
